// File: rtl/stash_scan_reader.sv
// stash_scan_reader: walks the scan table for one ORAM path, streams the
// stash entry addresses out in path order, then wipes the table to SNULL.
module stash_scan_reader #(
    parameter int ORAMZ           = 4,
    parameter int ORAML           = 3,
    parameter int StashEAWidth    = 8,
    parameter int ScanTableAWidth = 5
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Start,
    output logic                       Busy,
    output logic                       Done,
    output logic [ScanTableAWidth-1:0] STAddr,
    output logic                       STValid,
    output logic                       STReset,
    input  logic [StashEAWidth-1:0]    STData,
    input  logic                       STDataValid,
    output logic [StashEAWidth-1:0]    OutSAddr,
    output logic                       OutDummy,
    output logic                       OutValid,
    input  logic                       OutReady
);

    localparam int BlocksOnPath = (ORAML + 1) * ORAMZ;
    localparam logic [StashEAWidth-1:0] SNULL = '1;
    localparam logic [ScanTableAWidth-1:0] PathCnt =
        ScanTableAWidth'(BlocksOnPath);
    localparam logic [ScanTableAWidth-1:0] LastAddr =
        ScanTableAWidth'(BlocksOnPath - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        CLEAR,
        DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [ScanTableAWidth-1:0] r_rd_cnt;
    logic [ScanTableAWidth-1:0] r_out_cnt;
    logic [ScanTableAWidth-1:0] r_clr_cnt;
    logic                       r_pend;
    logic [StashEAWidth-1:0]    r_fifo0;
    logic [StashEAWidth-1:0]    r_fifo1;
    logic [1:0]                 r_fcnt;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_issue;
    logic [2:0]                 w_occ;

    // Output slot is the FIFO head, so it is held stable by construction.
    assign OutValid = (r_fcnt != 2'd0);
    assign OutSAddr = r_fifo0;
    assign OutDummy = (r_fifo0 == SNULL);

    assign w_pop  = OutValid & OutReady;
    assign w_push = STDataValid & r_pend;

    // Slots still claimed after this cycle's pop; a new read may take one.
    assign w_occ   = {1'b0, r_fcnt} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_issue = (r_state == SCAN) && (r_rd_cnt < PathCnt) &&
                     (w_occ < 3'd2);

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and table-port control.
    always_comb begin
        w_next  = r_state;
        Busy    = 1'b1;
        Done    = 1'b0;
        STValid = 1'b0;
        STReset = 1'b0;
        STAddr  = r_rd_cnt;
        unique case (r_state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    w_next = SCAN;
                end
            end
            SCAN: begin
                STValid = w_issue;
                if (r_rd_cnt == PathCnt) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (r_out_cnt == PathCnt) begin
                    w_next = CLEAR;
                end
            end
            CLEAR: begin
                STReset = 1'b1;
                STAddr  = r_clr_cnt;
                if (r_clr_cnt == LastAddr) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                Done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Read, output and clear counters; all restart on an accepted Start.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
            r_clr_cnt <= '0;
        end else if (r_state == IDLE && Start) begin
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
            r_clr_cnt <= '0;
        end else begin
            if (STValid) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end
            if (STReset) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // One read in flight; reset drops it so a late return is discarded.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= STValid;
        end
    end

    // Two-entry FIFO with the head always in r_fifo0.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_fcnt  <= 2'd0;
            r_fifo0 <= '0;
            r_fifo1 <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_fcnt == 2'd0) begin
                        r_fifo0 <= STData;
                    end else begin
                        r_fifo1 <= STData;
                    end
                    r_fcnt <= r_fcnt + 2'd1;
                end
                2'b01: begin
                    r_fifo0 <= r_fifo1;
                    r_fcnt  <= r_fcnt - 2'd1;
                end
                2'b11: begin
                    if (r_fcnt == 2'd1) begin
                        r_fifo0 <= STData;
                    end else begin
                        r_fifo0 <= r_fifo1;
                        r_fifo1 <= STData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SIMULATION
    // Flag table data that shows up with no read outstanding.
    always_ff @(posedge Clock) begin
        if (!Reset && STDataValid && !r_pend) begin
            $error("stash_scan_reader: unexpected STDataValid");
        end
    end
`endif

endmodule

// File: tb/tb_stash_scan_reader.sv
// tb_stash_scan_reader: directed bench with a one-cycle-latency scan
// table model and a negedge monitor for order, hold and clear behaviour.
module tb_stash_scan_reader;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Busy;
    logic       Done;
    logic [4:0] STAddr;
    logic       STValid;
    logic       STReset;
    logic [7:0] STData = 8'h00;
    logic       STDataValid = 1'b0;
    logic [7:0] OutSAddr;
    logic       OutDummy;
    logic       OutValid;
    logic       OutReady = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:31];

    int  mon_idx = 0;
    int  issued = 0;
    int  taken = 0;
    int  clr_idx = 0;
    int  done_cnt = 0;
    logic prev_hold = 1'b0;
    logic prev_done = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    time last_out_t = 0;
    time done_t = 0;

    stash_scan_reader dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Busy        (Busy),
        .Done        (Done),
        .STAddr      (STAddr),
        .STValid     (STValid),
        .STReset     (STReset),
        .STData      (STData),
        .STDataValid (STDataValid),
        .OutSAddr    (OutSAddr),
        .OutDummy    (OutDummy),
        .OutValid    (OutValid),
        .OutReady    (OutReady)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] expv(input int i);
        if (i == 2 || i == 9) return 8'hFF;
        if (i == 0) return 8'h03;
        if (i == 1) return 8'h07;
        return 8'h20 + 8'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scan table: read data returns one cycle after STValid.
    always @(posedge Clock) begin
        if (STReset) mem[STAddr] <= 8'hFF;
        STDataValid <= STValid;
        STData      <= STValid ? mem[STAddr] : 8'h00;
    end

    // Monitor: output order, hold, occupancy, clear sweep, Done pulse.
    always @(negedge Clock) begin
        if (Reset) begin
            mon_idx   = 0;
            issued    = 0;
            taken     = 0;
            clr_idx   = 0;
            prev_hold = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (Start && !Busy) begin
                mon_idx = 0;
                issued  = 0;
                taken   = 0;
                clr_idx = 0;
            end
            chk("no_valid_and_reset", {31'b0, STValid & STReset}, 0);
            if (prev_hold) begin
                chk("hold_valid", {31'b0, OutValid}, 1);
                chk("hold_addr", {24'b0, OutSAddr}, {24'b0, prev_addr});
            end
            if (OutValid && OutReady) begin
                chk("out_in_range", {31'b0, mon_idx < 16}, 1);
                chk("out_addr", {24'b0, OutSAddr}, {24'b0, expv(mon_idx)});
                chk("out_dummy", {31'b0, OutDummy},
                    {31'b0, expv(mon_idx) == 8'hFF});
                mon_idx++;
                taken++;
                last_out_t = $time;
            end
            if (STValid) issued++;
            if (Busy) chk("occupancy_le2", {31'b0, (issued - taken) <= 2}, 1);
            if (STReset) begin
                chk("clr_addr", {27'b0, STAddr}, clr_idx);
                clr_idx++;
            end
            if (Done) begin
                done_cnt++;
                done_t = $time;
                chk("done_one_cycle", {31'b0, prev_done}, 0);
            end
            prev_done = Done;
            prev_hold = OutValid && !OutReady;
            prev_addr = OutSAddr;
        end
    end

    task automatic fill();
        for (int i = 0; i < 32; i++) mem[i] <= (i < 16) ? expv(i) : 8'hFF;
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge Clock);
        #1 Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int k;
        k = 0;
        while (done_cnt == base && k < 500) begin
            @(negedge Clock);
            #2;
            k++;
        end
        chk("done_arrived", {31'b0, done_cnt != base}, 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, {31'b0, Busy}, 0);
        chk({tag, "_done"}, {31'b0, Done}, 0);
        chk({tag, "_stvalid"}, {31'b0, STValid}, 0);
        chk({tag, "_streset"}, {31'b0, STReset}, 0);
        chk({tag, "_outvalid"}, {31'b0, OutValid}, 0);
    endtask

    task automatic check_table_cleared();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("table_ff_%0d", i), {24'b0, mem[i]}, 32'hFF);
        end
    endtask

    initial begin
        int base;
        int gap;
        int k;

        fill();
        repeat (2) @(posedge Clock);
        #1;
        check_idle("reset");
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;

        // Full pass with OutReady high.
        base = done_cnt;
        OutReady = 1'b1;
        pulse_start();
        @(negedge Clock);
        chk("a_first_stvalid", {31'b0, STValid}, 1);
        chk("a_first_staddr", {27'b0, STAddr}, 0);
        chk("a_c1_outvalid", {31'b0, OutValid}, 0);
        @(negedge Clock);
        chk("a_c2_outvalid", {31'b0, OutValid}, 0);
        @(negedge Clock);
        chk("a_c3_outvalid", {31'b0, OutValid}, 1);
        chk("a_c3_outsaddr", {24'b0, OutSAddr}, 32'h03);
        wait_done(base);
        gap = int'((done_t - last_out_t) / 10);
        chk("a_done_gap", {31'b0, gap >= 16 && gap <= 18}, 1);
        chk("a_out_count", mon_idx, 16);
        chk("a_clear_count", clr_idx, 16);
        chk("a_done_count", done_cnt, base + 1);
        check_table_cleared();
        @(negedge Clock);
        check_idle("a_after");

        // OutReady toggling every cycle.
        fill();
        base = done_cnt;
        pulse_start();
        k = 0;
        while (done_cnt == base && k < 300) begin
            @(posedge Clock);
            #1 OutReady = !OutReady;
            k++;
        end
        OutReady = 1'b1;
        wait_done(base);
        chk("b_out_count", mon_idx, 16);
        chk("b_done_count", done_cnt, base + 1);

        // Downstream stalled for 20 cycles.
        fill();
        base = done_cnt;
        OutReady = 1'b0;
        pulse_start();
        repeat (20) @(negedge Clock);
        #2;
        chk("c_reads_issued", issued, 2);
        chk("c_outvalid", {31'b0, OutValid}, 1);
        chk("c_outsaddr", {24'b0, OutSAddr}, 32'h03);
        chk("c_nothing_taken", mon_idx, 0);
        chk("c_busy", {31'b0, Busy}, 1);
        @(posedge Clock);
        #1 OutReady = 1'b1;
        wait_done(base);
        chk("c_out_count", mon_idx, 16);
        chk("c_done_count", done_cnt, base + 1);

        // Start pulsed while busy, in SCAN and in CLEAR.
        fill();
        base = done_cnt;
        pulse_start();
        repeat (4) @(posedge Clock);
        pulse_start();
        k = 0;
        while (!STReset && k < 100) begin
            @(negedge Clock);
            k++;
        end
        chk("d_reached_clear", {31'b0, STReset}, 1);
        pulse_start();
        wait_done(base);
        repeat (10) @(posedge Clock);
        #1;
        chk("d_done_count", done_cnt, base + 1);
        chk("d_idle", {31'b0, Busy}, 0);
        chk("d_out_count", mon_idx, 16);

        // Reset on the fifth output cycle, then rescan.
        fill();
        pulse_start();
        k = 0;
        while (mon_idx != 5 && k < 100) begin
            @(negedge Clock);
            #2;
            k++;
        end
        chk("e_reached_fifth", mon_idx, 5);
        Reset = 1'b1;
        #1;
        check_idle("e_reset");
        @(posedge Clock);
        @(posedge Clock);
        #1 Reset = 1'b0;
        base = done_cnt;
        pulse_start();
        @(negedge Clock);
        chk("e_rescan_stvalid", {31'b0, STValid}, 1);
        chk("e_rescan_staddr", {27'b0, STAddr}, 0);
        wait_done(base);
        chk("e_out_count", mon_idx, 16);
        chk("e_done_count", done_cnt, base + 1);
        check_table_cleared();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
